srl_tap_delay: RTL and testbench

Parametrised multi-bit, variable-tap delay line for the SRL inference flow. A WIDTH-bit word advances through DEPTH stages on each enabled clock. A run-time address selects which stage drives the output, the way an addressable SRL primitive does. A fill counter tracks how many stages hold valid data, and the output is qualified by it.

---
 rtl/srl_tap_delay.sv | 81 ++++++++
 tb/tb_srl_tap_delay.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/srl_tap_delay.sv
// Purpose : WIDTH-bit delay line of DEPTH stages with a run-time tap select, SRL-mappable.
// Latency : addr+1 enabled edges from d to q; tap changes reach q combinationally.
// Backpres: none; en stalls the whole line and the fill count together.
//
// Ports:
//   clk, rst_n   clock, async active-low reset (control state only)
//   en           shift enable
//   clr          synchronous flush of the fill count (data stages untouched)
//   d            word shifted into stage 0
//   addr         tap select, clamped to DEPTH-1
//   q, q_valid   selected tap data, zeroed unless the tap holds data since reset/clr
//   fill         number of valid stages, 0..DEPTH
module srl_tap_delay #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic [AW-1:0]    addr,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [AW:0]      fill
);

    localparam logic [AW:0] FILL_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0] FILL_ONE = (AW+1)'(1);

    // Data stages carry no reset or clear so they can map onto shift-register
    // primitives; stale contents are hidden by the fill count instead.
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            stage[0] <= d;
            for (int k = 1; k < DEPTH; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    // Fill counter: clr with en restarts at 1 because this cycle's d is valid.
    logic [AW:0] fill_q;
    logic [AW:0] fill_nxt;

    always_comb begin
        fill_nxt = fill_q;
        if (clr) begin
            fill_nxt = en ? FILL_ONE : '0;
        end else if (en && (fill_q != FILL_MAX)) begin
            fill_nxt = fill_q + FILL_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_nxt;
        end
    end

    assign fill = fill_q;

    // Tap clamp only exists when DEPTH leaves unused address codes.
    logic [AW-1:0] a_eff;

    if ((1 << AW) == DEPTH) begin : g_pow2
        assign a_eff = addr;
    end else begin : g_clamp
        localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
        assign a_eff = (addr > LAST) ? LAST : addr;
    end

    assign q_valid = (fill_q > {1'b0, a_eff});
    assign q       = q_valid ? stage[a_eff] : '0;

endmodule

// File: tb/tb_srl_tap_delay.sv
// Purpose : directed checks of srl_tap_delay at 8x32 and at 130x130 (clamp path).
// Latency : inputs driven 1 time unit after posedge, outputs sampled there too.
// Backpres: n/a.
module tb_srl_tap_delay;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WIDTH=8, DEPTH=32
    logic        rst_n_a = 1'b1;
    logic        en_a    = 1'b0;
    logic        clr_a   = 1'b0;
    logic [7:0]  d_a     = '0;
    logic [4:0]  addr_a  = '0;
    logic [7:0]  q_a;
    logic        q_valid_a;
    logic [5:0]  fill_a;

    srl_tap_delay #(.WIDTH(8), .DEPTH(32)) u_dut_a (
        .clk     (clk),
        .rst_n   (rst_n_a),
        .en      (en_a),
        .clr     (clr_a),
        .d       (d_a),
        .addr    (addr_a),
        .q       (q_a),
        .q_valid (q_valid_a),
        .fill    (fill_a)
    );

    // Instance B: WIDTH=130, DEPTH=130, AW=8
    logic         rst_n_b = 1'b1;
    logic         en_b    = 1'b0;
    logic         clr_b   = 1'b0;
    logic [129:0] d_b     = '0;
    logic [7:0]   addr_b  = '0;
    logic [129:0] q_b;
    logic         q_valid_b;
    logic [8:0]   fill_b;

    srl_tap_delay #(.WIDTH(130), .DEPTH(130)) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_n_b),
        .en      (en_b),
        .clr     (clr_b),
        .d       (d_b),
        .addr    (addr_b),
        .q       (q_b),
        .q_valid (q_valid_b),
        .fill    (fill_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [129:0] wgen(input int i);
        logic [63:0] lo;
        logic [63:0] mid;
        lo  = 64'hDEAD_BEEF_0000_0000 | 64'(i);
        mid = 64'(i * 37 + 5);
        return {2'(i), mid, lo};
    endfunction

    initial begin
        #1;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;

        // 1. Reset holds outputs at zero even with en=1 and random data
        en_a   = 1'b1;
        addr_a = 5'd5;
        for (int i = 0; i < 3; i++) begin
            d_a = 8'($urandom);
            step();
            check("rst_q",     q_a,       0);
            check("rst_valid", q_valid_a, 0);
            check("rst_fill",  fill_a,    0);
        end
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        d_a     = 8'h01;
        step();
        check("post_rst_fill",  fill_a,    1);
        check("post_rst_valid", q_valid_a, 0);

        // 2. Fixed tap latency, addr=3
        en_a  = 1'b0;
        clr_a = 1'b1;
        step();
        clr_a  = 1'b0;
        en_a   = 1'b1;
        addr_a = 5'd3;
        for (int i = 1; i <= 5; i++) begin
            d_a = 8'(i);
            step();
            check("lat_fill",  fill_a,    i);
            check("lat_valid", q_valid_a, (i >= 4) ? 1 : 0);
            check("lat_q",     q_a,       (i >= 4) ? i - 3 : 0);
        end

        // 3. Enable gaps: enabled on every other clock
        en_a  = 1'b0;
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        begin
            int e;
            e = 0;
            for (int c = 1; c <= 10; c++) begin
                en_a = (c % 2) == 1;
                if (en_a) begin
                    e++;
                    d_a = 8'(e);
                end else begin
                    d_a = 8'hEE;
                end
                step();
                check("gap_fill",  fill_a,    e);
                check("gap_valid", q_valid_a, (e >= 4) ? 1 : 0);
                check("gap_q",     q_a,       (e >= 4) ? e - 3 : 0);
            end
        end

        // 4. Saturation and dynamic address
        en_a  = 1'b0;
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        en_a  = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            d_a = 8'(i);
            step();
            if (i == 32) check("sat_fill32", fill_a, 32);
        end
        en_a = 1'b0;
        check("sat_fill40", fill_a, 32);
        addr_a = 5'd31;
        #1;
        check("sat_q31", q_a, 9);
        addr_a = 5'd0;
        #1;
        check("sat_q0", q_a, 40);
        for (int a = 0; a < 32; a++) begin
            addr_a = 5'(a);
            #1;
            check("sweep_q",     q_a,       40 - a);
            check("sweep_valid", q_valid_a, 1);
        end

        // 5. clr interaction
        clr_a = 1'b1;
        en_a  = 1'b0;
        step();
        clr_a = 1'b0;
        check("clr_fill", fill_a, 0);
        for (int a = 0; a < 32; a++) begin
            addr_a = 5'(a);
            #1;
            check("clr_q",     q_a,       0);
            check("clr_valid", q_valid_a, 0);
        end
        clr_a = 1'b1;
        en_a  = 1'b1;
        d_a   = 8'hAA;
        step();
        clr_a = 1'b0;
        en_a  = 1'b0;
        check("clren_fill", fill_a, 1);
        addr_a = 5'd0;
        #1;
        check("clren_q0",     q_a,       8'hAA);
        check("clren_valid0", q_valid_a, 1);
        addr_a = 5'd1;
        #1;
        check("clren_q1",     q_a,       0);
        check("clren_valid1", q_valid_a, 0);

        // 6. 130x130: fill, address clamp, async reset
        en_b = 1'b1;
        for (int i = 0; i < 130; i++) begin
            d_b = wgen(i);
            step();
        end
        en_b = 1'b0;
        check("b_fill", fill_b, 130);
        addr_b = 8'd200;
        #1;
        check("b_clamp_q",     q_b,       wgen(0));
        check("b_clamp_valid", q_valid_b, 1);
        addr_b = 8'd129;
        #1;
        check("b_q129", q_b, wgen(0));
        addr_b = 8'd0;
        #1;
        check("b_q0", q_b, wgen(129));
        addr_b = 8'd200;
        rst_n_b = 1'b0;
        #1;
        check("b_arst_q",     q_b,       0);
        check("b_arst_valid", q_valid_b, 0);
        check("b_arst_fill",  fill_b,    0);
        step();
        rst_n_b = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
